// File: rtl/bitcount_pkg.sv
// Shared types and helpers for the bitcount_stream slice.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package bitcount_pkg;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Widest accumulator sat_add can serve; ACC_W must not exceed this.
  localparam int SAT_MAX_W = 64;

  // Bits needed to hold a population count of a width-bit word (0..width).
  function automatic int cw_f(input int width);
    return $clog2(width + 1);
  endfunction

  // Saturating add clamped to a w-bit all-ones ceiling. Operands are
  // zero-extended into SAT_MAX_W bits; ovf reports that clamping happened.
  function automatic logic [SAT_MAX_W-1:0] sat_add(
    input  logic [SAT_MAX_W-1:0] a,
    input  logic [SAT_MAX_W-1:0] b,
    input  int                   w,
    output logic                 ovf
  );
    logic [SAT_MAX_W:0] sum;
    logic [SAT_MAX_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ({{SAT_MAX_W{1'b0}}, 1'b1} << w) - {{SAT_MAX_W{1'b0}}, 1'b1};
    if (sum > lim) begin
      ovf = 1'b1;
      return lim[SAT_MAX_W-1:0];
    end
    ovf = 1'b0;
    return sum[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count as a balanced binary adder tree.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows input.
module popcount_tree
  import bitcount_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         data,
  output logic [cw_f(WIDTH)-1:0]   count
);

  localparam int CW = cw_f(WIDTH);

  generate
    if (WIDTH == 1) begin : g_leaf
      assign count = data;
    end else begin : g_node
      localparam int LW = WIDTH / 2;
      localparam int HW = WIDTH - LW;

      logic [cw_f(LW)-1:0] lo_cnt;
      logic [cw_f(HW)-1:0] hi_cnt;

      popcount_tree #(.WIDTH(LW)) u_lo (
        .data  (data[LW-1:0]),
        .count (lo_cnt)
      );

      popcount_tree #(.WIDTH(HW)) u_hi (
        .data  (data[WIDTH-1:LW]),
        .count (hi_cnt)
      );

      assign count = CW'(lo_cnt) + CW'(hi_cnt);
    end
  endgenerate

endmodule

// File: rtl/bitcount_stream.sv
// Per-frame bit statistics: saturating match-bit, beat and (with BITCOUNT_ONEHOT_EN) one-hot counts.
// Latency: last beat accepted in cycle t -> out_valid in cycle t+2; next frame may start the cycle after the result handshake.
// Backpressure: in_ready drops from last-beat acceptance until the held result is taken by out_ready.
module bitcount_stream
  import bitcount_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ACC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_last,
  input  logic              match_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_count,
  output logic [ACC_W-1:0]  out_beats,
  output logic [ACC_W-1:0]  out_onehot,
  output logic [ACC_W-1:0]  out_onehot0,
  output logic              out_ovf
);

  localparam int CW = cw_f(WIDTH);

  state_e            state_q, state_d;
  logic              beat_acc;
  logic              res_take;
  logic [CW-1:0]     pc;

  logic              s1_vld_q, s1_vld_d;
  logic              s1_last_q, s1_last_d;
  logic [CW-1:0]     s1_cnt_q, s1_cnt_d;

  logic [ACC_W-1:0]  cnt_acc_q, cnt_acc_d;
  logic [ACC_W-1:0]  beats_acc_q, beats_acc_d;
  logic              ovf_q, ovf_d;
  logic              cnt_sat, beats_sat;
  logic              oh_ovf;

  assign beat_acc = in_valid && in_ready;
  assign res_take = out_valid && out_ready;

  popcount_tree #(.WIDTH(WIDTH)) u_popcount (
    .data  (in_data),
    .count (pc)
  );

  // Frame FSM: accept beats, wait for the last beat to clear both stages, hold the result.
  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == ACC);
    out_valid = (state_q == HOLD);
    unique case (state_q)
      ACC:     if (beat_acc && in_last) state_d = DRAIN;
      DRAIN:   if (s1_vld_q && s1_last_q) state_d = HOLD;
      HOLD:    if (out_ready) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // Stage 1: capture the per-beat matching-bit count and last flag of an accepted beat.
  always_comb begin
    s1_vld_d  = beat_acc;
    s1_last_d = s1_last_q;
    s1_cnt_d  = s1_cnt_q;
    if (beat_acc) begin
      s1_last_d = in_last;
      s1_cnt_d  = match_val ? pc : (CW'(WIDTH) - pc);
    end
  end

  // Stage 2: saturating frame accumulators; taking the result clears them for the next frame.
  always_comb begin
    cnt_acc_d   = cnt_acc_q;
    beats_acc_d = beats_acc_q;
    ovf_d       = ovf_q;
    cnt_sat     = 1'b0;
    beats_sat   = 1'b0;
    if (res_take) begin
      cnt_acc_d   = '0;
      beats_acc_d = '0;
      ovf_d       = 1'b0;
    end else if (s1_vld_q) begin
      cnt_acc_d   = ACC_W'(sat_add(SAT_MAX_W'(cnt_acc_q), SAT_MAX_W'(s1_cnt_q), ACC_W, cnt_sat));
      beats_acc_d = ACC_W'(sat_add(SAT_MAX_W'(beats_acc_q), SAT_MAX_W'(1), ACC_W, beats_sat));
      ovf_d       = ovf_q | cnt_sat | beats_sat | oh_ovf;
    end
  end

  // State, stage-1 and accumulator registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_cnt_q    <= '0;
      cnt_acc_q   <= '0;
      beats_acc_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_vld_q    <= s1_vld_d;
      s1_last_q   <= s1_last_d;
      s1_cnt_q    <= s1_cnt_d;
      cnt_acc_q   <= cnt_acc_d;
      beats_acc_q <= beats_acc_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_count = cnt_acc_q;
  assign out_beats = beats_acc_q;
  assign out_ovf   = ovf_q;

`ifdef BITCOUNT_ONEHOT_EN
  logic             s1_oh_q, s1_oh_d;
  logic             s1_oh0_q, s1_oh0_d;
  logic [ACC_W-1:0] oh_acc_q, oh_acc_d;
  logic [ACC_W-1:0] oh0_acc_q, oh0_acc_d;
  logic             oh_sat, oh0_sat;

  // Stage 1: classify the accepted word as one-hot / zero-or-one-hot.
  always_comb begin
    s1_oh_d  = s1_oh_q;
    s1_oh0_d = s1_oh0_q;
    if (beat_acc) begin
      s1_oh_d  = (pc == CW'(1));
      s1_oh0_d = (pc <= CW'(1));
    end
  end

  // Stage 2: saturating one-hot counters, cleared alongside the main accumulators.
  always_comb begin
    oh_acc_d  = oh_acc_q;
    oh0_acc_d = oh0_acc_q;
    oh_sat    = 1'b0;
    oh0_sat   = 1'b0;
    if (res_take) begin
      oh_acc_d  = '0;
      oh0_acc_d = '0;
    end else if (s1_vld_q) begin
      oh_acc_d  = ACC_W'(sat_add(SAT_MAX_W'(oh_acc_q), SAT_MAX_W'(s1_oh_q), ACC_W, oh_sat));
      oh0_acc_d = ACC_W'(sat_add(SAT_MAX_W'(oh0_acc_q), SAT_MAX_W'(s1_oh0_q), ACC_W, oh0_sat));
    end
  end

  // One-hot stage-1 flags and counters with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_oh_q   <= 1'b0;
      s1_oh0_q  <= 1'b0;
      oh_acc_q  <= '0;
      oh0_acc_q <= '0;
    end else begin
      s1_oh_q   <= s1_oh_d;
      s1_oh0_q  <= s1_oh0_d;
      oh_acc_q  <= oh_acc_d;
      oh0_acc_q <= oh0_acc_d;
    end
  end

  assign out_onehot  = oh_acc_q;
  assign out_onehot0 = oh0_acc_q;
  assign oh_ovf      = oh_sat | oh0_sat;
`else
  assign out_onehot  = '0;
  assign out_onehot0 = '0;
  assign oh_ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_bitcount_stream.sv
// Testbench for bitcount_stream at ACC_W=16 and ACC_W=8 driven in lockstep.
// Latency: expects out_valid two cycles after the last beat and in_ready the cycle after the result handshake.
// Backpressure: holds out_ready low for random spans and checks outputs stay put.
module tb_bitcount_stream;

  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_last;
  logic              match_val;
  logic              out_ready;
  logic [WIDTH-1:0]  in_data;

  logic              ir_a, ov_a, ovf_a;
  logic [15:0]       cnt_a, beats_a, oh_a, oh0_a;
  logic              ir_b, ov_b, ovf_b;
  logic [7:0]        cnt_b, beats_b, oh_b, oh0_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] fd[16];
  bit          fm[16];
  int          fn;

  always #5 clk = ~clk;

  bitcount_stream #(.WIDTH(WIDTH), .ACC_W(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data), .in_last(in_last),
    .match_val(match_val),
    .out_valid(ov_a), .out_ready(out_ready),
    .out_count(cnt_a), .out_beats(beats_a), .out_onehot(oh_a), .out_onehot0(oh0_a),
    .out_ovf(ovf_a)
  );

  bitcount_stream #(.WIDTH(WIDTH), .ACC_W(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir_b), .in_data(in_data), .in_last(in_last),
    .match_val(match_val),
    .out_valid(ov_b), .out_ready(out_ready),
    .out_count(cnt_b), .out_beats(beats_b), .out_onehot(oh_b), .out_onehot0(oh0_b),
    .out_ovf(ovf_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: whole-frame totals from the word list, then clamp to the accumulator ceiling.
  task automatic expect_res(input int aw, output logic [63:0] c, output logic [63:0] b,
                            output logic [63:0] oh, output logic [63:0] oh0, output logic ovf);
    longint mx, tc, tb, to, to0;
    int pc;
    mx = (64'd1 << aw) - 64'd1;
    tc = 0; tb = 0; to = 0; to0 = 0;
    for (int i = 0; i < fn; i++) begin
      pc = $countones(fd[i]);
      tc += fm[i] ? pc : (WIDTH - pc);
      tb += 1;
      if (pc == 1) to += 1;
      if (pc <= 1) to0 += 1;
    end
`ifndef BITCOUNT_ONEHOT_EN
    to = 0;
    to0 = 0;
`endif
    ovf = (tc > mx) || (tb > mx) || (to > mx) || (to0 > mx);
    c   = (tc  > mx) ? mx : tc;
    b   = (tb  > mx) ? mx : tb;
    oh  = (to  > mx) ? mx : to;
    oh0 = (to0 > mx) ? mx : to0;
  endtask

  task automatic check_result(input string tag);
    logic [63:0] c, b, oh, oh0;
    logic ovf;
    expect_res(16, c, b, oh, oh0, ovf);
    check({tag, ".cnt16"},   64'(cnt_a),   c);
    check({tag, ".beats16"}, 64'(beats_a), b);
    check({tag, ".oh16"},    64'(oh_a),    oh);
    check({tag, ".oh016"},   64'(oh0_a),   oh0);
    check({tag, ".ovf16"},   64'(ovf_a),   64'(ovf));
    expect_res(8, c, b, oh, oh0, ovf);
    check({tag, ".cnt8"},    64'(cnt_b),   c);
    check({tag, ".beats8"},  64'(beats_b), b);
    check({tag, ".oh8"},     64'(oh_b),    oh);
    check({tag, ".oh08"},    64'(oh0_b),   oh0);
    check({tag, ".ovf8"},    64'(ovf_b),   64'(ovf));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".hs"}, {ir_a, ir_b, ov_a, ov_b}, 64'b1100);
    check({tag, ".zero16"}, {cnt_a, beats_a, oh_a, oh0_a, 15'd0, ovf_a}, 64'd0);
    check({tag, ".zero8"},  {cnt_b, beats_b, oh_b, oh0_b, 31'd0, ovf_b}, 64'd0);
  endtask

  // Random traffic on the input while the DUT is not ready; it must be ignored.
  task automatic junk_inputs;
    in_valid  = 1'($urandom_range(1));
    in_data   = $urandom;
    match_val = 1'($urandom_range(1));
    in_last   = 1'($urandom_range(1));
  endtask

  task automatic run_frame(input int hold, input string tag);
    for (int i = 0; i < fn; i++) begin
      in_valid  = 1'b1;
      in_data   = fd[i];
      match_val = fm[i];
      in_last   = (i == fn - 1);
      check({tag, ".rdy"}, {ir_a, ir_b}, 64'b11);
      tick;
    end
    junk_inputs;
    check({tag, ".lat1"}, {ov_a, ov_b, ir_a, ir_b}, 64'b0000);
    tick;
    junk_inputs;
    check({tag, ".lat2"}, {ov_a, ov_b}, 64'b11);
    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      check_result({tag, ".hold"});
      check({tag, ".holdrdy"}, {ir_a, ir_b, ov_a, ov_b}, 64'b0011);
      tick;
      junk_inputs;
    end
    out_ready = 1'b1;
    check_result(tag);
    tick;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    check({tag, ".post"}, {ir_a, ir_b, ov_a, ov_b}, 64'b1100);
  endtask

  function automatic logic [31:0] rand_word(input int mode);
    case (mode)
      0:       return $urandom;
      1:       return 32'h1 << $urandom_range(31);
      2:       return 32'h0;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    match_val = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick;
    check_idle("reset");
    tick;
    rst = 1'b0;
    tick;
    check_idle("reset_rel");

    fn = 1; fd[0] = 32'h0000_00A5; fm[0] = 1'b1;
    run_frame(0, "single_a5");

    fn = 3;
    fd[0] = 32'h1;         fm[0] = 1'b1;
    fd[1] = 32'h8000_0000; fm[1] = 1'b1;
    fd[2] = 32'h0;         fm[2] = 1'b1;
    run_frame(0, "three_oh");

    fn = 2;
    fd[0] = 32'h0;         fm[0] = 1'b0;
    fd[1] = 32'hFFFF_FFFF; fm[1] = 1'b1;
    run_frame(1, "mixed_sel");

    fn = 9;
    for (int i = 0; i < 9; i++) begin
      fd[i] = 32'hFFFF_FFFF;
      fm[i] = 1'b1;
    end
    run_frame(0, "sat9");

    fn = 2; fd[0] = 32'h0F0F_1234; fm[0] = 1'b1; fd[1] = 32'h0000_0040; fm[1] = 1'b0;
    run_frame(5, "hold5");
    fn = 1; fd[0] = 32'h0000_00FF; fm[0] = 1'b1;
    run_frame(0, "after_hold");

    // Reset in the middle of an open frame, with a last beat offered in the reset cycle.
    for (int i = 0; i < 2; i++) begin
      in_valid  = 1'b1;
      in_data   = 32'hFFFF_0000;
      match_val = 1'b1;
      in_last   = 1'b0;
      tick;
    end
    in_last = 1'b1;
    rst     = 1'b1;
    tick;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_idle("rst_mid");
    for (int k = 0; k < 3; k++) begin
      tick;
      check_idle("rst_quiet");
    end
    fn = 1; fd[0] = 32'h3; fm[0] = 1'b1;
    run_frame(0, "after_rst");

    for (int f = 0; f < 40; f++) begin
      int mode;
      fn   = 1 + $urandom_range(11);
      mode = $urandom_range(3);
      for (int i = 0; i < fn; i++) begin
        fd[i] = rand_word(($urandom_range(3) == 0) ? mode : $urandom_range(3));
        fm[i] = 1'($urandom_range(1));
      end
      run_frame($urandom_range(3), $sformatf("rand%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
